spu_issue_stage: RTL and testbench

- Dual-issue dispatch stage directly upstream of RF_FU_Pipe_wrapper.
- Accepts an in-order pair of decoded instructions (slot A older, slot B younger) from decode. Routes each to the even or odd pipe.
- Holds instructions on RAW/WAW/structural hazards using a per-register latency scoreboard.
- Drives the wrapper's even/odd instruction, immediate and register-address inputs from registers.

---
 rtl/spu_issue_pkg.sv | 37 +++
 rtl/spu_issue_stage_scoreboard.sv | 32 +++
 rtl/spu_issue_stage.sv | 128 ++++++++++++
 tb/tb_spu_issue_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_issue_pkg.sv
// spu_issue_pkg: shared field widths, pipe/state encodings and instruction bundles for the SPU issue stage
package spu_issue_pkg;
  localparam int INSTR_W = 32;
  localparam int ID_W = 7;
  localparam int REG_W = 7;
  localparam int UNIT_W = 3;
  localparam int LATENCY_W = 4;
  localparam int I7_W = 7;
  localparam int I10_W = 10;
  localparam int I16_W = 16;
  localparam int I18_W = 18;
  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} pipe_e;
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_PAIR = 2'd2} state_e;
  typedef struct packed {
    logic [INSTR_W-1:0] full_instr;
    logic [ID_W-1:0] instr_id;
    logic [REG_W-1:0] reg_dst;
    logic [UNIT_W-1:0] unit_id;
    logic [LATENCY_W-1:0] latency;
    logic reg_wr;
    logic [I7_W-1:0] imme7;
    logic [I10_W-1:0] imme10;
    logic [I16_W-1:0] imme16;
    logic [I18_W-1:0] imme18;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
  } issue_t;
  typedef struct packed {
    issue_t f;
    pipe_e pipe;
    logic [2:0] src_used;
  } instr_t;
  function automatic logic reads(input instr_t x, input logic [REG_W-1:0] r);
    return (x.src_used[0] && x.f.ra == r) || (x.src_used[1] && x.f.rb == r) || (x.src_used[2] && x.f.rc == r);
  endfunction
endpackage

// File: rtl/spu_issue_stage_scoreboard.sv
// spu_scoreboard: per-register result-latency counters with six busy lookups and two WAW compares
module spu_scoreboard
  import spu_issue_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int LAT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [1:0] i_set_en,
  input  logic [1:0][REG_W-1:0] i_set_reg,
  input  logic [1:0][LAT_W-1:0] i_set_lat,
  input  logic [5:0][REG_W-1:0] i_rd_reg,
  output logic [5:0] o_busy,
  input  logic [1:0][REG_W-1:0] i_waw_reg,
  input  logic [1:0][LAT_W-1:0] i_waw_lat,
  output logic [1:0] o_waw
);
  logic [LAT_W-1:0] r_cnt [NUM_REGS];
  for (genvar i = 0; i < 6; i++) begin : g_rd
    assign o_busy[i] = r_cnt[i_rd_reg[i]] > LAT_W'(1);
  end
  for (genvar i = 0; i < 2; i++) begin : g_waw
    assign o_waw[i] = r_cnt[i_waw_reg[i]] > i_waw_lat[i];
  end
  always_ff @(posedge clk)
    for (int r = 0; r < NUM_REGS; r++)
      if (!rst) r_cnt[r] <= '0;
      else if (i_set_en[1] && i_set_reg[1] == REG_W'(r)) r_cnt[r] <= i_set_lat[1];
      else if (i_set_en[0] && i_set_reg[0] == REG_W'(r)) r_cnt[r] <= i_set_lat[0];
      else if (r_cnt[r] != '0) r_cnt[r] <= r_cnt[r] - LAT_W'(1);
endmodule

// File: rtl/spu_issue_stage.sv
// spu_issue_stage: dual-issue dispatch buffering a decoded pair and issuing hazard-free instructions to the even/odd pipes
module spu_issue_stage
  import spu_issue_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int LAT_W = 4,
  parameter logic [ID_W-1:0] NOP_ID = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in_valid,
  output logic o_in_ready,
  input  logic i_flush,
  input  logic [INSTR_W-1:0] i_a_full_instr, i_b_full_instr,
  input  logic [ID_W-1:0] i_a_instr_id, i_b_instr_id,
  input  logic [REG_W-1:0] i_a_reg_dst, i_b_reg_dst,
  input  logic [UNIT_W-1:0] i_a_unit_id, i_b_unit_id,
  input  logic [LATENCY_W-1:0] i_a_latency, i_b_latency,
  input  logic i_a_reg_wr, i_b_reg_wr,
  input  logic i_a_pipe, i_b_pipe,
  input  logic i_a_valid, i_b_valid,
  input  logic [I7_W-1:0] i_a_imme7, i_b_imme7,
  input  logic [I10_W-1:0] i_a_imme10, i_b_imme10,
  input  logic [I16_W-1:0] i_a_imme16, i_b_imme16,
  input  logic [I18_W-1:0] i_a_imme18, i_b_imme18,
  input  logic [REG_W-1:0] i_a_ra, i_a_rb, i_a_rc, i_b_ra, i_b_rb, i_b_rc,
  input  logic [2:0] i_a_src_used, i_b_src_used,
  output logic [INSTR_W-1:0] o_full_instr_even, o_full_instr_odd,
  output logic [ID_W-1:0] o_instr_id_even, o_instr_id_odd,
  output logic [REG_W-1:0] o_reg_dst_even, o_reg_dst_odd,
  output logic [UNIT_W-1:0] o_unit_id_even, o_unit_id_odd,
  output logic [LATENCY_W-1:0] o_latency_even, o_latency_odd,
  output logic o_reg_wr_even, o_reg_wr_odd,
  output logic [I7_W-1:0] o_imme7_even, o_imme7_odd,
  output logic [I10_W-1:0] o_imme10_even, o_imme10_odd,
  output logic [I16_W-1:0] o_imme16_even, o_imme16_odd,
  output logic [I18_W-1:0] o_imme18_even, o_imme18_odd,
  output logic [REG_W-1:0] o_ra_addr_even, o_rb_addr_even, o_rc_addr_even,
  output logic [REG_W-1:0] o_ra_addr_odd, o_rb_addr_odd, o_rc_addr_odd,
  output logic [15:0] o_stall_cnt
);
  state_e r_state;
  instr_t r_a, r_b;
  issue_t r_even, r_odd;
  logic [15:0] r_stall;
  instr_t w_in_a, w_in_b;
  issue_t w_nop, w_even, w_odd;
  logic [5:0] w_busy;
  logic [1:0] w_waw;
  logic w_a_iss, w_b_iss, w_b_dep, w_capture;
  assign w_in_a = {i_a_full_instr, i_a_instr_id, i_a_reg_dst, i_a_unit_id, i_a_latency, i_a_reg_wr, i_a_imme7, i_a_imme10,
                   i_a_imme16, i_a_imme18, i_a_ra, i_a_rb, i_a_rc, i_a_pipe, i_a_src_used};
  assign w_in_b = {i_b_full_instr, i_b_instr_id, i_b_reg_dst, i_b_unit_id, i_b_latency, i_b_reg_wr, i_b_imme7, i_b_imme10,
                   i_b_imme16, i_b_imme18, i_b_ra, i_b_rb, i_b_rc, i_b_pipe, i_b_src_used};
  spu_scoreboard #(.NUM_REGS(NUM_REGS), .LAT_W(LAT_W)) u_sb (
    .clk(clk),
    .rst(rst),
    .i_set_en({w_b_iss && r_b.f.reg_wr && r_b.f.latency != '0, w_a_iss && r_a.f.reg_wr && r_a.f.latency != '0}),
    .i_set_reg({r_b.f.reg_dst, r_a.f.reg_dst}),
    .i_set_lat({LAT_W'(r_b.f.latency), LAT_W'(r_a.f.latency)}),
    .i_rd_reg({r_b.f.rc, r_b.f.rb, r_b.f.ra, r_a.f.rc, r_a.f.rb, r_a.f.ra}),
    .o_busy(w_busy),
    .i_waw_reg({r_b.f.reg_dst, r_a.f.reg_dst}),
    .i_waw_lat({LAT_W'(r_b.f.latency), LAT_W'(r_a.f.latency)}),
    .o_waw(w_waw)
  );
  assign w_a_iss = r_state != S_EMPTY && !i_flush && !(|(w_busy[2:0] & r_a.src_used) || (r_a.f.reg_wr && w_waw[0]));
  assign w_b_dep = r_a.f.reg_wr && (reads(r_b, r_a.f.reg_dst) || (r_b.f.reg_wr && r_b.f.reg_dst == r_a.f.reg_dst));
  assign w_b_iss = r_state == S_PAIR && w_a_iss && r_b.pipe != r_a.pipe && !w_b_dep &&
                   !(|(w_busy[5:3] & r_b.src_used) || (r_b.f.reg_wr && w_waw[1]));
  assign o_in_ready = rst && (r_state == S_EMPTY || (w_a_iss && (r_state == S_ONE || w_b_iss)));
  assign w_capture = o_in_ready && i_in_valid && !i_flush;
  always_comb begin
    w_nop = '0;
    w_nop.instr_id = NOP_ID;
    w_even = w_a_iss && r_a.pipe == EVEN ? r_a.f : w_b_iss && r_b.pipe == EVEN ? r_b.f : w_nop;
    w_odd = w_a_iss && r_a.pipe == ODD ? r_a.f : w_b_iss && r_b.pipe == ODD ? r_b.f : w_nop;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= S_EMPTY;
      r_a <= '0;
      r_b <= '0;
      r_even <= '0;
      r_odd <= '0;
      r_stall <= '0;
    end else begin
      r_even <= w_even;
      r_odd <= w_odd;
      if (r_state != S_EMPTY && !w_a_iss && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
      if (i_flush) r_state <= S_EMPTY;
      else if (w_capture) begin
        r_state <= i_a_valid && i_b_valid ? S_PAIR : i_a_valid || i_b_valid ? S_ONE : S_EMPTY;
        r_a <= i_a_valid ? w_in_a : w_in_b;
        r_b <= w_in_b;
      end else if (w_a_iss) begin
        r_state <= r_state == S_PAIR && !w_b_iss ? S_ONE : S_EMPTY;
        r_a <= r_b;
      end
    end
  assign o_full_instr_even = r_even.full_instr;
  assign o_instr_id_even = r_even.instr_id;
  assign o_reg_dst_even = r_even.reg_dst;
  assign o_unit_id_even = r_even.unit_id;
  assign o_latency_even = r_even.latency;
  assign o_reg_wr_even = r_even.reg_wr;
  assign o_imme7_even = r_even.imme7;
  assign o_imme10_even = r_even.imme10;
  assign o_imme16_even = r_even.imme16;
  assign o_imme18_even = r_even.imme18;
  assign o_ra_addr_even = r_even.ra;
  assign o_rb_addr_even = r_even.rb;
  assign o_rc_addr_even = r_even.rc;
  assign o_full_instr_odd = r_odd.full_instr;
  assign o_instr_id_odd = r_odd.instr_id;
  assign o_reg_dst_odd = r_odd.reg_dst;
  assign o_unit_id_odd = r_odd.unit_id;
  assign o_latency_odd = r_odd.latency;
  assign o_reg_wr_odd = r_odd.reg_wr;
  assign o_imme7_odd = r_odd.imme7;
  assign o_imme10_odd = r_odd.imme10;
  assign o_imme16_odd = r_odd.imme16;
  assign o_imme18_odd = r_odd.imme18;
  assign o_ra_addr_odd = r_odd.ra;
  assign o_rb_addr_odd = r_odd.rb;
  assign o_rc_addr_odd = r_odd.rc;
  assign o_stall_cnt = r_stall;
endmodule

// File: tb/tb_spu_issue_stage.sv
// tb_spu_issue_stage: directed scoreboard bench for the dual-issue dispatch stage
module tb_spu_issue_stage;
  typedef struct {
    int cyc;
    logic p;
    logic [6:0] id;
    logic [6:0] dst;
    logic [3:0] lat;
  } exp_t;
  logic clk = 0, rst, in_valid, flush;
  logic [31:0] full[2];
  logic [6:0] id[2], dst[2], ra[2], rb[2], rc[2], i7[2];
  logic [2:0] unit[2], used[2];
  logic [3:0] lat[2];
  logic wr[2], pipe[2], vld[2];
  logic [9:0] i10[2];
  logic [15:0] i16[2];
  logic [17:0] i18[2];
  logic o_in_ready;
  logic [31:0] o_full_instr_even, o_full_instr_odd;
  logic [6:0] o_instr_id_even, o_instr_id_odd, o_reg_dst_even, o_reg_dst_odd;
  logic [2:0] o_unit_id_even, o_unit_id_odd;
  logic [3:0] o_latency_even, o_latency_odd;
  logic o_reg_wr_even, o_reg_wr_odd;
  logic [6:0] o_imme7_even, o_imme7_odd;
  logic [9:0] o_imme10_even, o_imme10_odd;
  logic [15:0] o_imme16_even, o_imme16_odd;
  logic [17:0] o_imme18_even, o_imme18_odd;
  logic [6:0] o_ra_addr_even, o_rb_addr_even, o_rc_addr_even, o_ra_addr_odd, o_rb_addr_odd, o_rc_addr_odd;
  logic [15:0] o_stall_cnt;
  logic any_out;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, c;
  spu_issue_stage dut (
    .clk(clk), .rst(rst), .i_in_valid(in_valid), .o_in_ready(o_in_ready), .i_flush(flush),
    .i_a_full_instr(full[0]), .i_b_full_instr(full[1]), .i_a_instr_id(id[0]), .i_b_instr_id(id[1]),
    .i_a_reg_dst(dst[0]), .i_b_reg_dst(dst[1]), .i_a_unit_id(unit[0]), .i_b_unit_id(unit[1]),
    .i_a_latency(lat[0]), .i_b_latency(lat[1]), .i_a_reg_wr(wr[0]), .i_b_reg_wr(wr[1]),
    .i_a_pipe(pipe[0]), .i_b_pipe(pipe[1]), .i_a_valid(vld[0]), .i_b_valid(vld[1]),
    .i_a_imme7(i7[0]), .i_b_imme7(i7[1]), .i_a_imme10(i10[0]), .i_b_imme10(i10[1]),
    .i_a_imme16(i16[0]), .i_b_imme16(i16[1]), .i_a_imme18(i18[0]), .i_b_imme18(i18[1]),
    .i_a_ra(ra[0]), .i_a_rb(rb[0]), .i_a_rc(rc[0]), .i_b_ra(ra[1]), .i_b_rb(rb[1]), .i_b_rc(rc[1]),
    .i_a_src_used(used[0]), .i_b_src_used(used[1]),
    .o_full_instr_even(o_full_instr_even), .o_full_instr_odd(o_full_instr_odd),
    .o_instr_id_even(o_instr_id_even), .o_instr_id_odd(o_instr_id_odd),
    .o_reg_dst_even(o_reg_dst_even), .o_reg_dst_odd(o_reg_dst_odd),
    .o_unit_id_even(o_unit_id_even), .o_unit_id_odd(o_unit_id_odd),
    .o_latency_even(o_latency_even), .o_latency_odd(o_latency_odd),
    .o_reg_wr_even(o_reg_wr_even), .o_reg_wr_odd(o_reg_wr_odd),
    .o_imme7_even(o_imme7_even), .o_imme7_odd(o_imme7_odd),
    .o_imme10_even(o_imme10_even), .o_imme10_odd(o_imme10_odd),
    .o_imme16_even(o_imme16_even), .o_imme16_odd(o_imme16_odd),
    .o_imme18_even(o_imme18_even), .o_imme18_odd(o_imme18_odd),
    .o_ra_addr_even(o_ra_addr_even), .o_rb_addr_even(o_rb_addr_even), .o_rc_addr_even(o_rc_addr_even),
    .o_ra_addr_odd(o_ra_addr_odd), .o_rb_addr_odd(o_rb_addr_odd), .o_rc_addr_odd(o_rc_addr_odd),
    .o_stall_cnt(o_stall_cnt)
  );
  assign any_out = |{o_full_instr_even, o_instr_id_even, o_reg_dst_even, o_unit_id_even, o_latency_even, o_reg_wr_even,
                     o_imme7_even, o_imme10_even, o_imme16_even, o_imme18_even, o_ra_addr_even, o_rb_addr_even,
                     o_rc_addr_even, o_full_instr_odd, o_instr_id_odd, o_reg_dst_odd, o_unit_id_odd, o_latency_odd,
                     o_reg_wr_odd, o_imme7_odd, o_imme10_odd, o_imme16_odd, o_imme18_odd, o_ra_addr_odd,
                     o_rb_addr_odd, o_rc_addr_odd};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic slot(input int s, input logic v, input logic [6:0] iid, input logic p, input logic [6:0] d,
                      input logic [3:0] l, input logic w, input logic [2:0] u, input logic [6:0] a, b, cc);
    vld[s] = v;
    id[s] = iid;
    pipe[s] = p;
    dst[s] = d;
    lat[s] = l;
    wr[s] = w;
    used[s] = u;
    ra[s] = a;
    rb[s] = b;
    rc[s] = cc;
    full[s] = {iid, 25'h1555555};
    i7[s] = iid;
    i10[s] = {3'b0, iid};
    i16[s] = {iid, 9'h0AB};
    i18[s] = {11'h0, iid};
    unit[s] = 3'(s + 1);
  endtask
  task automatic expect_issue(input int cy, input logic p, input logic [6:0] iid, input logic [6:0] d, input logic [3:0] l);
    q.push_back('{cy, p, iid, d, l});
  endtask
  task automatic got(input logic p, input logic [6:0] iid, input logic [6:0] d, input logic [3:0] l,
                     input logic [31:0] w, input logic [15:0] im);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_issue", {57'h0, iid}, 64'h0);
      return;
    end
    e = q.pop_front();
    chk("issue_cycle", 64'(cyc), 64'(e.cyc));
    chk("issue_pipe", {63'h0, p}, {63'h0, e.p});
    chk("issue_id", {57'h0, iid}, {57'h0, e.id});
    chk("issue_dst", {57'h0, d}, {57'h0, e.dst});
    chk("issue_lat", {60'h0, l}, {60'h0, e.lat});
    chk("issue_word", {32'h0, w}, {32'h0, e.id, 25'h1555555});
    chk("issue_imm16", {48'h0, im}, {48'h0, e.id, 9'h0AB});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (o_instr_id_even != 7'd0) got(1'b0, o_instr_id_even, o_reg_dst_even, o_latency_even, o_full_instr_even, o_imme16_even);
    if (o_instr_id_odd != 7'd0) got(1'b1, o_instr_id_odd, o_reg_dst_odd, o_latency_odd, o_full_instr_odd, o_imme16_odd);
  endtask
  initial begin
    rst = 0;
    in_valid = 0;
    flush = 0;
    slot(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_in_ready", {63'h0, o_in_ready}, 64'h0);
    chk("rst_stall", {48'h0, o_stall_cnt}, 64'h0);
    chk("rst_outs", {63'h0, any_out}, 64'h0);
    rst = 1;
    #1 chk("idle_ready", {63'h0, o_in_ready}, 64'h1);
    slot(0, 1, 10, 0, 3, 2, 1, 3'b001, 5, 0, 0);
    slot(1, 1, 11, 1, 4, 2, 1, 3'b001, 6, 0, 0);
    in_valid = 1;
    c = cyc;
    expect_issue(c + 2, 0, 10, 3, 2);
    expect_issue(c + 2, 1, 11, 4, 2);
    tick();
    in_valid = 0;
    chk("pair_ready", {63'h0, o_in_ready}, 64'h1);
    tick();
    chk("pair_ready_after", {63'h0, o_in_ready}, 64'h1);
    slot(0, 1, 69, 1, 8, 1, 1, 0, 0, 0, 0);
    slot(1, 1, 70, 1, 9, 1, 1, 0, 0, 0, 0);
    in_valid = 1;
    c = cyc;
    expect_issue(c + 2, 1, 69, 8, 1);
    expect_issue(c + 3, 1, 70, 9, 1);
    tick();
    in_valid = 0;
    chk("same_pipe_ready0", {63'h0, o_in_ready}, 64'h0);
    tick();
    chk("same_pipe_even_nop", {57'h0, o_instr_id_even}, 64'h0);
    chk("same_pipe_ready1", {63'h0, o_in_ready}, 64'h1);
    tick();
    slot(0, 1, 20, 0, 1, 4, 1, 0, 0, 0, 0);
    slot(1, 1, 21, 1, 2, 1, 1, 3'b001, 1, 0, 0);
    in_valid = 1;
    c = cyc;
    expect_issue(c + 2, 0, 20, 1, 4);
    expect_issue(c + 6, 1, 21, 2, 1);
    tick();
    in_valid = 0;
    repeat (5) tick();
    chk("raw_pair_stall", {48'h0, o_stall_cnt}, 64'd3);
    slot(0, 1, 30, 0, 1, 6, 1, 0, 0, 0, 0);
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1;
    c = cyc;
    expect_issue(c + 2, 0, 30, 1, 6);
    expect_issue(c + 8, 1, 31, 11, 0);
    tick();
    slot(0, 1, 31, 1, 11, 0, 0, 3'b010, 0, 1, 0);
    tick();
    in_valid = 0;
    repeat (6) tick();
    chk("raw_cross_stall", {48'h0, o_stall_cnt}, 64'd8);
    slot(0, 1, 40, 0, 10, 1, 1, 0, 0, 0, 0);
    in_valid = 1;
    c = cyc;
    expect_issue(c + 2, 0, 40, 10, 1);
    expect_issue(c + 3, 1, 41, 12, 0);
    tick();
    slot(0, 1, 41, 1, 12, 0, 0, 3'b100, 0, 0, 10);
    tick();
    in_valid = 0;
    tick();
    slot(0, 1, 42, 0, 12, 5, 1, 0, 0, 0, 0);
    in_valid = 1;
    c = cyc;
    expect_issue(c + 2, 0, 42, 12, 5);
    expect_issue(c + 6, 1, 43, 12, 2);
    tick();
    slot(0, 1, 43, 1, 12, 2, 1, 0, 0, 0, 0);
    tick();
    in_valid = 0;
    repeat (4) tick();
    chk("waw_stall", {48'h0, o_stall_cnt}, 64'd11);
    slot(0, 1, 50, 0, 1, 6, 1, 0, 0, 0, 0);
    slot(1, 1, 51, 1, 2, 1, 1, 3'b001, 1, 0, 0);
    in_valid = 1;
    c = cyc;
    expect_issue(c + 2, 0, 50, 1, 6);
    tick();
    in_valid = 0;
    tick();
    flush = 1;
    tick();
    flush = 0;
    chk("flush_even_nop", {57'h0, o_instr_id_even}, 64'h0);
    chk("flush_odd_nop", {57'h0, o_instr_id_odd}, 64'h0);
    chk("flush_empty_ready", {63'h0, o_in_ready}, 64'h1);
    chk("flush_stall", {48'h0, o_stall_cnt}, 64'd12);
    slot(0, 1, 52, 1, 3, 0, 0, 3'b001, 1, 0, 0);
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1;
    expect_issue(c + 8, 1, 52, 3, 0);
    tick();
    in_valid = 0;
    repeat (4) tick();
    chk("post_flush_stall", {48'h0, o_stall_cnt}, 64'd15);
    slot(0, 1, 60, 0, 4, 1, 1, 0, 0, 0, 0);
    slot(1, 1, 61, 1, 5, 1, 1, 0, 0, 0, 0);
    in_valid = 1;
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    tick();
    chk("flush_no_capture_even", {57'h0, o_instr_id_even}, 64'h0);
    chk("flush_no_capture_odd", {57'h0, o_instr_id_odd}, 64'h0);
    slot(0, 1, 70, 0, 1, 8, 1, 0, 0, 0, 0);
    slot(1, 1, 71, 1, 2, 1, 1, 3'b001, 1, 0, 0);
    in_valid = 1;
    c = cyc;
    expect_issue(c + 2, 0, 70, 1, 8);
    tick();
    in_valid = 0;
    repeat (3) tick();
    chk("stall_before_rst", {48'h0, o_stall_cnt}, 64'd17);
    rst = 0;
    tick();
    chk("midrst_outs", {63'h0, any_out}, 64'h0);
    chk("midrst_stall", {48'h0, o_stall_cnt}, 64'h0);
    chk("midrst_ready", {63'h0, o_in_ready}, 64'h0);
    rst = 1;
    slot(0, 1, 80, 0, 5, 2, 1, 3'b001, 1, 0, 0);
    slot(1, 1, 81, 1, 6, 2, 1, 3'b010, 0, 1, 0);
    in_valid = 1;
    c = cyc;
    expect_issue(c + 2, 0, 80, 5, 2);
    expect_issue(c + 2, 1, 81, 6, 2);
    tick();
    in_valid = 0;
    tick();
    tick();
    chk("post_rst_stall", {48'h0, o_stall_cnt}, 64'h0);
    chk("queue_empty", 64'(q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
